comparador_serial_ctrl: RTL and testbench
=========================================

# comparador_serial_ctrl

Sequencing controller for the left-to-right (MSB-first) magnitude comparator built from `celdaTipica` cells. It runs the comparison bit-serially: a single `celdaTipica` instance is fed one operand bit pair per clock. The cell's `(P,Q)` outputs are registered and fed back as its `(p,q)` inputs on the next cycle, in place of the N-cell ripple chain. The block captures operands on a start handshake, steps through N bits, optionally stops early once the result is decided, and presents a one-hot greater/equal/less result with a done pulse.

## Interface
- `N`, 8, operand width in bits (N ≥ 2)
- `EARLY_EXIT`, 0, 1 = finish as soon as the comparison is decided; 0 = always consume all N bits
- `clk` input 1: single clock, all state updates on rising edge
- `reset` input 1: synchronous, active-high
- `start` input 1: request a comparison; sampled only in IDLE
- `A` input N: operand A, captured when start is accepted
- `B` input N: operand B, captured when start is accepted
- `busy` output 1: high in RUN and DONE
- `done` output 1: one-cycle pulse, result valid
- `gt` output 1: A > B
- `eq` output 1: A == B
- `lt` output 1: A < B
- `bit_idx` output $clog2(N): index of the bit being fed to the cell this cycle

## Operation
- Cell state contract (fixed team encoding of `(p,q)`):
  - (0,1) = equal so far; this is also the init value.
  - (1,1) = A > B.
  - (0,0) = A < B.
  - A decided state is absorbing: the cell holds it regardless of Ai/Bi.
  - In the equal state, the next state follows Ai/Bi: (1,0) → gt, (0,1) → lt, equal bits → stay equal.
- Internal registers:
  - `sa`, `sb`: N-bit shift registers, MSB fed to the cell.
  - `pr`, `qr`: registered cell state.
  - `cnt`: bits remaining.
- State machine, 2-bit register, states IDLE, RUN, DONE:
  - IDLE: `busy` = 0. On `start` = 1:
    - sa ← A, sb ← B, (pr,qr) ← (0,1), cnt ← N, bit_idx ← N−1.
    - Clear gt/eq/lt.
    - Go to RUN.
  - RUN: cell inputs are p = pr, q = qr, Ai = sa[N−1], Bi = sb[N−1]. Each cycle:
    - (pr,qr) ← (P,Q).
    - sa, sb shift left by 1, zero fill.
    - cnt ← cnt−1, bit_idx ← bit_idx−1.
    - Go to DONE when cnt == 1, or when EARLY_EXIT = 1 and (P,Q) ≠ (0,1).
  - DONE: `done` = 1 for exactly one cycle.
    - gt/eq/lt are set on entry to DONE, decoded from (pr,qr): (1,1) → gt, (0,1) → eq, (0,0) → lt.
    - Code (1,0) is illegal: all three results stay 0 and the block still returns to IDLE.
    - Next state: IDLE unconditionally.
- Result hold: gt/eq/lt remain valid after DONE until the next accepted `start` clears them. Exactly one of them is high whenever holding a legal result.
- `start` in RUN or DONE is ignored. It is not queued, and operands are not re-captured.
- `A`/`B` changes after capture have no effect on a running comparison.
- `reset` has priority over everything, including mid-RUN:
  - State → IDLE.
  - busy = done = gt = eq = lt = 0.
  - bit_idx = 0, (pr,qr) = (0,1), sa = sb = 0, cnt = 0.

## Timing
- `start` is sampled at edge k (state IDLE) → RUN during cycles k+1 … k+m.
  - EARLY_EXIT = 0: m = N.
  - EARLY_EXIT = 1: m = j+1, where j = position from the MSB (0 = MSB) of the first differing bit. If the operands are equal, m = N.
- `done` is high in cycle k+m+1. Results are valid from cycle k+m+1 onward.
- Earliest next accepted `start`: edge k+m+2 (first IDLE cycle). Throughput with EARLY_EXIT = 0 is one comparison per N+2 cycles.
- `busy` is high in cycles k+1 … k+m+1.
- `bit_idx` equals N−1−i during RUN cycle k+1+i. Its value outside RUN is don't-care but must be stable.
- The cell path is purely combinational inside the block. No multicycle paths.

## Test plan
- N=3, EARLY_EXIT=0, A=110, B=101, start pulsed at edge 0 → bit_idx 2,1,0 in cycles 1–3; done = 1 in cycle 4; gt = 1, eq = lt = 0, held until next start.
- N=8, A=B=0x5A, then A=0x3C, B=0xC3 → first run: eq = 1 after N+1 = 9 cycles; second run: lt = 1 after 9 cycles; eq is cleared on the second start.
- N=8, EARLY_EXIT=1, A=0x80, B=0x7F → done in cycle 2 after start with gt = 1. Then A=0x01, B=0x00 → done in cycle 9 with gt = 1.
- Start held high through a full run, with A/B changed mid-RUN → exactly one done per IDLE entry. Result reflects the operands captured at acceptance. A new run starts on the first IDLE cycle.
- reset asserted in the 3rd RUN cycle → next cycle busy = done = gt = eq = lt = 0 and state IDLE. A new start after reset completes normally with a correct result.
- Exhaustive N=3 (64 A/B pairs) against a reference model, for both EARLY_EXIT values → result matches, exactly one of gt/eq/lt is set, and done latency matches the formula above.

Source files
------------

// File: rtl/comparador_serial_ctrl_if.sv
// Start/operand/result bundle for the bit-serial magnitude comparator.
interface comparador_serial_ctrl_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;

  logic          start;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          busy;
  logic          done;
  logic          gt;
  logic          eq;
  logic          lt;
  logic [BW-1:0] bit_idx;

  modport master (
    output start, a, b,
    input  busy, done, gt, eq, lt, bit_idx
  );

  modport slave (
    input  start, a, b,
    output busy, done, gt, eq, lt, bit_idx
  );
endinterface

// File: rtl/comparador_serial_ctrl.sv
// Bit-serial MSB-first magnitude comparator: one celdaTipica cell whose (P,Q)
// outputs are registered and fed back as (p,q) on the next bit.
module comparador_serial_ctrl #(
  parameter int unsigned N          = 8,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input logic                    clk,
  input logic                    reset,
  comparador_serial_ctrl_if.slave bus
);
  localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [N-1:0]  sa;
  logic [N-1:0]  sb;
  logic          pr;
  logic          qr;
  logic [CW-1:0] cnt;
  logic          busy_r;
  logic          done_r;
  logic          gt_r;
  logic          eq_r;
  logic          lt_r;
  logic [BW-1:0] bit_idx_r;
  logic          cell_p_c;
  logic          cell_q_c;
  logic          decided_c;

  // Cell: (0,1) equal follows the bit pair; (1,1) gt and (0,0) lt are absorbing
  always_comb begin
    cell_p_c = pr;
    cell_q_c = qr;
    if (!pr && qr) begin
      cell_p_c = sa[N-1] & ~sb[N-1];
      cell_q_c = ~(~sa[N-1] & sb[N-1]);
    end
    decided_c = EARLY_EXIT && ({cell_p_c, cell_q_c} != 2'b01);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if ((cnt == CW'(1)) || decided_c) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and registered outputs; results are decoded from the final cell state
  always_ff @(posedge clk) begin
    if (reset) begin
      sa        <= '0;
      sb        <= '0;
      pr        <= 1'b0;
      qr        <= 1'b1;
      cnt       <= '0;
      bit_idx_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      gt_r      <= 1'b0;
      eq_r      <= 1'b0;
      lt_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa        <= bus.a;
            sb        <= bus.b;
            pr        <= 1'b0;
            qr        <= 1'b1;
            cnt       <= CW'(N);
            bit_idx_r <= BW'(N - 1);
            busy_r    <= 1'b1;
            gt_r      <= 1'b0;
            eq_r      <= 1'b0;
            lt_r      <= 1'b0;
          end
        end
        RUN: begin
          pr        <= cell_p_c;
          qr        <= cell_q_c;
          sa        <= sa << 1;
          sb        <= sb << 1;
          cnt       <= cnt - CW'(1);
          bit_idx_r <= bit_idx_r - BW'(1);
          if (state_nx == DONE) begin
            done_r <= 1'b1;
            gt_r   <= cell_p_c & cell_q_c;
            eq_r   <= ~cell_p_c & cell_q_c;
            lt_r   <= ~cell_p_c & ~cell_q_c;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.gt      = gt_r;
  assign bus.eq      = eq_r;
  assign bus.lt      = lt_r;
  assign bus.bit_idx = bit_idx_r;
endmodule

// File: tb/tb_comparador_serial_ctrl.sv
// Directed bench for comparador_serial_ctrl: four instances covering N=3/8 and
// both EARLY_EXIT settings, with an exhaustive N=3 sweep against an index model.
module tb_comparador_serial_ctrl;
  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  logic       clk;
  logic       reset;
  logic       start_v [4];
  logic [7:0] a_v     [4];
  logic [7:0] b_v     [4];
  logic [3:0] busy_o;
  logic [3:0] done_o;
  logic [2:0] res_o   [4];
  logic [2:0] bidx_o  [4];

  int nvec;
  int nmis;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instances 0/1: N=3, 2/3: N=8; odd instances have early exit enabled
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned NN = (g < 2) ? 3 : 8;
    comparador_serial_ctrl_if #(.N(NN)) bus ();
    comparador_serial_ctrl #(.N(NN), .EARLY_EXIT((g % 2) == 1)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );
    assign bus.start = start_v[g];
    assign bus.a     = a_v[g][NN-1:0];
    assign bus.b     = b_v[g][NN-1:0];
    assign busy_o[g] = bus.busy;
    assign done_o[g] = bus.done;
    assign res_o[g]  = {bus.gt, bus.eq, bus.lt};
    assign bidx_o[g] = 3'(bus.bit_idx);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: scan from the MSB for the first differing bit
  task automatic ref_cmp(input int n, input bit ee, input logic [7:0] av, input logic [7:0] bv,
                         output logic [2:0] code, output int m);
    code = EQ;
    m    = n;
    for (int i = n - 1; i >= 0; i--) begin
      if (av[i] != bv[i]) begin
        code = av[i] ? GT : LT;
        if (ee) m = n - i;
        break;
      end
    end
  endtask

  // One comparison: accept, track bit_idx per RUN cycle, check latency/result/hold
  task automatic run(input int d, input logic [7:0] av, input logic [7:0] bv,
                     input logic [2:0] expv, input int m);
    int n;
    int t;
    n = (d < 2) ? 3 : 8;
    a_v[d]     = av;
    b_v[d]     = bv;
    start_v[d] = 1'b1;
    step();
    start_v[d] = 1'b0;
    t = 1;
    check("clr", 32'(res_o[d]), 32'(0));
    while (!done_o[d] && t <= 20) begin
      check("busy", 32'(busy_o[d]), 32'(1));
      if (t <= m) check("bidx", 32'(bidx_o[d]), 32'(n - t));
      step();
      t++;
    end
    check("lat", 32'(t), 32'(m + 1));
    check("res", 32'(res_o[d]), 32'(expv));
    check("onehot", 32'($countones(res_o[d])), 32'(1));
    step();
    check("dlow", 32'(done_o[d]), 32'(0));
    check("idle", 32'(busy_o[d]), 32'(0));
    check("hold", 32'(res_o[d]), 32'(expv));
  endtask

  initial begin
    logic [2:0] c;
    int         m;
    int         dcount;
    nvec  = 0;
    nmis  = 0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_v[i] = 1'b0;
      a_v[i]     = '0;
      b_v[i]     = '0;
    end
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      check("rst_busy", 32'(busy_o[i]), 32'(0));
      check("rst_done", 32'(done_o[i]), 32'(0));
      check("rst_res", 32'(res_o[i]), 32'(0));
      check("rst_bidx", 32'(bidx_o[i]), 32'(0));
    end
    reset = 1'b0;
    step();

    run(0, 8'b110, 8'b101, GT, 3);
    run(2, 8'h5A, 8'h5A, EQ, 8);
    run(2, 8'h3C, 8'hC3, LT, 8);
    run(3, 8'h80, 8'h7F, GT, 1);
    run(3, 8'h01, 8'h00, GT, 8);

    // start held high across two runs, operands changed mid-RUN
    a_v[2]     = 8'h10;
    b_v[2]     = 8'h20;
    start_v[2] = 1'b1;
    step();
    dcount = 0;
    for (int t = 1; t <= 20; t++) begin
      if (t == 3) begin
        a_v[2] = 8'hFF;
        b_v[2] = 8'h00;
      end
      if (t == 10) begin
        check("gap_busy", 32'(busy_o[2]), 32'(0));
        check("gap_hold", 32'(res_o[2]), 32'(LT));
      end
      if (t == 11) begin
        start_v[2] = 1'b0;
        check("rerun_busy", 32'(busy_o[2]), 32'(1));
        check("rerun_clr", 32'(res_o[2]), 32'(0));
      end
      if (done_o[2]) begin
        dcount++;
        check("held_dcyc", 32'(t), (dcount == 1) ? 32'(9) : 32'(19));
        check("held_res", 32'(res_o[2]), (dcount == 1) ? 32'(LT) : 32'(GT));
      end
      step();
    end
    check("held_ndone", 32'(dcount), 32'(2));

    // reset during the third RUN cycle
    a_v[2]     = 8'hAA;
    b_v[2]     = 8'h55;
    start_v[2] = 1'b1;
    step();
    start_v[2] = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_busy", 32'(busy_o[2]), 32'(0));
    check("mrst_done", 32'(done_o[2]), 32'(0));
    check("mrst_res", 32'(res_o[2]), 32'(0));
    check("mrst_bidx", 32'(bidx_o[2]), 32'(0));
    run(2, 8'h12, 8'h34, LT, 8);

    // exhaustive N=3, both exit modes
    for (int d = 0; d < 2; d++) begin
      for (int x = 0; x < 8; x++) begin
        for (int y = 0; y < 8; y++) begin
          ref_cmp(3, d == 1, 8'(x), 8'(y), c, m);
          run(d, 8'(x), 8'(y), c, m);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
